// File: rtl/ctrl_poll_sched.sv
// ctrl_poll_sched
// Autonomous slow-control poller. It walks an 8-entry table of
// (chipid, register address) pairs and issues one register read per enabled
// entry through the arbiter's readout requester port. Each returned value is
// packed as {chipid, addr, data} into a 4-deep first-word-fall-through FIFO
// for the event packer. A sweep is started by the period timer or by a
// software start pulse.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i, period_i    periodic sweep timer enable and period (cycles)
//   start_i               single-cycle software sweep request
//   cfg_we_i/idx/en/      table entry write port
//   chipid/addr
//   rdo_opcode_o/chipid_o/addr_o/rd_o   read request toward the arbiter
//   rdo_ack_i, rdo_data_i               arbiter ack with same-cycle data
//   out_data_o, out_valid_o, out_ready_i  FIFO output, pop = valid & ready
//   busy_o                sweep in progress
//   missed_o              saturating count of timer ticks lost while busy
module ctrl_poll_sched #(
  parameter logic [7:0]  RD_OPCODE = 8'h4E,
  parameter int unsigned PERIOD_W  = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                start_i,
  input  logic                cfg_we_i,
  input  logic [2:0]          cfg_idx_i,
  input  logic                cfg_en_i,
  input  logic [7:0]          cfg_chipid_i,
  input  logic [15:0]         cfg_addr_i,
  output logic [7:0]          rdo_opcode_o,
  output logic [7:0]          rdo_chipid_o,
  output logic [15:0]         rdo_addr_o,
  output logic                rdo_rd_o,
  input  logic                rdo_ack_i,
  input  logic [15:0]         rdo_data_i,
  output logic [39:0]         out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic [7:0]          missed_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;

  localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic [7:0]          missed_q, missed_d;
  logic                rd_q, rd_d;
  logic [7:0]          req_chip_q, req_chip_d;
  logic [15:0]         req_addr_q, req_addr_d;

  logic [7:0]          tbl_en_q, tbl_en_d;
  logic [7:0]          tbl_chip_q [8];
  logic [7:0]          tbl_chip_d [8];
  logic [15:0]         tbl_addr_q [8];
  logic [15:0]         tbl_addr_d [8];

  logic [39:0]         fifo_mem_q [4];
  logic [39:0]         fifo_mem_d [4];
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]          fifo_cnt_q, fifo_cnt_d;

  logic                tick;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                last_idx;

  // Period timer. The ">=" compare makes the counter recover immediately if
  // period_i is reduced below the current count while running.
  always_comb begin
    tick  = 1'b0;
    tmr_d = '0;
    if (enable_i && (period_i != '0)) begin
      if (tmr_q >= (period_i - ONE_P)) begin
        tick  = 1'b1;
        tmr_d = '0;
      end else begin
        tmr_d = tmr_q + ONE_P;
      end
    end
  end

  // Table write port, usable at any time. SCAN reads the registered table,
  // so an entry written ahead of the scan index is seen in the current sweep.
  always_comb begin
    tbl_en_d   = tbl_en_q;
    tbl_chip_d = tbl_chip_q;
    tbl_addr_d = tbl_addr_q;
    if (cfg_we_i) begin
      tbl_en_d[cfg_idx_i]   = cfg_en_i;
      tbl_chip_d[cfg_idx_i] = cfg_chipid_i;
      tbl_addr_d[cfg_idx_i] = cfg_addr_i;
    end
  end

  // FIFO bookkeeping. A push can only happen on an ack in REQ, and REQ is
  // only entered when a slot was free, so push never meets a full FIFO.
  assign fifo_full = (fifo_cnt_q == 3'd4);
  assign push      = (state_q == ST_REQ) && rdo_ack_i;
  assign pop       = (fifo_cnt_q != 3'd0) && out_ready_i;

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {req_chip_q, req_addr_q, rdo_data_i};
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Sweep sequencer. The request fields are latched on issue and only
  // reloaded from SCAN, so table writes never disturb an outstanding read.
  assign last_idx = (idx_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    req_chip_d = req_chip_q;
    req_addr_d = req_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (tick || start_i) begin
          state_d = ST_SCAN;
          idx_d   = 3'd0;
        end
      end
      ST_SCAN: begin
        if (!tbl_en_q[idx_q]) begin
          idx_d = idx_q + 3'd1;
          if (last_idx) begin
            state_d = ST_IDLE;
          end
        end else if (!fifo_full) begin
          req_chip_d = tbl_chip_q[idx_q];
          req_addr_d = tbl_addr_q[idx_q];
          rd_d       = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rdo_ack_i) begin
          rd_d    = 1'b0;
          idx_d   = idx_q + 3'd1;
          state_d = last_idx ? ST_IDLE : ST_SCAN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
      end
    endcase
  end

  // Ticks landing during a sweep are dropped, not queued; only counted.
  always_comb begin
    missed_d = missed_q;
    if (tick && (state_q != ST_IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      missed_q   <= '0;
      rd_q       <= 1'b0;
      req_chip_q <= '0;
      req_addr_q <= '0;
      tbl_en_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < 8; i++) begin
        tbl_chip_q[i] <= '0;
        tbl_addr_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      missed_q   <= missed_d;
      rd_q       <= rd_d;
      req_chip_q <= req_chip_d;
      req_addr_q <= req_addr_d;
      tbl_en_q   <= tbl_en_d;
      tbl_chip_q <= tbl_chip_d;
      tbl_addr_q <= tbl_addr_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign rdo_opcode_o = RD_OPCODE;
  assign rdo_chipid_o = req_chip_q;
  assign rdo_addr_o   = req_addr_q;
  assign rdo_rd_o     = rd_q;
  assign out_data_o   = fifo_mem_q[rd_ptr_q];
  assign out_valid_o  = (fifo_cnt_q != 3'd0);
  assign busy_o       = (state_q != ST_IDLE);
  assign missed_o     = missed_q;

endmodule

// File: doc/ctrl_poll_sched.md
Name: ctrl_poll_sched

Overview:
Autonomous slow-control poller. It sweeps a programmable table of up to 8 (chipid, register address) entries and issues one read per enabled entry through the readout port of the control arbiter (rdo_* requester). Each returned register value is packed with its chipid and address and buffered in a 4-deep FIFO toward the event/USB packer. Sweeps start on a programmable period timer or on a software start pulse.

Parameters:
RD_OPCODE, 8'h4E, opcode driven on rdo_opcode_o (ALPIDE register read).
PERIOD_W, 24, width of period counter/period_i.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  periodic timer enable
period_i  in  PERIOD_W  sweep period in clk cycles
start_i  in  1  single-cycle software sweep request
cfg_we_i  in  1  table entry write strobe
cfg_idx_i  in  3  table entry index
cfg_en_i  in  1  entry enable bit
cfg_chipid_i  in  8  entry chipid
cfg_addr_i  in  16  entry register address
rdo_opcode_o  out  8  to arbiter, constant RD_OPCODE
rdo_chipid_o  out  8  to arbiter
rdo_addr_o  out  16  to arbiter
rdo_rd_o  out  1  read request, level, held until ack
rdo_ack_i  in  1  arbiter ack, 1 cycle, data valid same cycle
rdo_data_i  in  16  ctrl read data (ctrl_data_i)
out_data_o  out  40  {chipid[7:0], addr[15:0], data[15:0]}
out_valid_o  out  1  FIFO not empty (first-word-fall-through)
out_ready_i  in  1  consumer pop; pop = valid & ready
busy_o  out  1  sweep in progress (state != IDLE)
missed_o  out  8  saturating count of timer ticks lost while busy

Behaviour:
- Reset: all outputs 0 (rdo_opcode_o = RD_OPCODE); all table entries disabled, chipid/addr 0; FIFO emptied; timer 0; missed_o 0; state IDLE. Reset mid-request drops rdo_rd_o on that edge; pending ack ignored.
- Timer: when enable_i=1 and period_i!=0, counter increments per cycle; at count==period_i-1 generates tick and returns to 0. enable_i=0 or period_i=0: counter held at 0, no ticks.
- States: IDLE, SCAN, REQ.
- IDLE: tick or start_i -> SCAN with idx=0. Both same cycle = one sweep.
- SCAN: examines entry idx, one entry per cycle.
  - Entry disabled: idx+1; after idx 7 -> IDLE.
  - Entry enabled and FIFO not full: latch chipid/addr onto rdo_*; rdo_rd_o=1 from next edge; -> REQ.
  - Entry enabled and FIFO full: stay in SCAN on the same idx (stall), no request.
- REQ: rdo_rd_o held 1 with stable chipid/addr until rdo_ack_i.
  - On the ack edge: push {chipid, addr, rdo_data_i}; rdo_rd_o=0 next cycle, so the arbiter never sees a second request; idx+1 -> SCAN, or IDLE after idx 7.
- Latency: trigger at cycle 0, entry 0 enabled -> rdo_rd_o high cycle 2. Ack cycle k -> out_valid_o high cycle k+1 if FIFO was empty.
- Sweep with no enabled entries: 8 SCAN cycles, no request, no output.
- Tick while busy: missed_o+1, saturating at 255; no sweep queued. start_i while busy: ignored, not counted.
- Config writes are accepted in any state, last write wins. An entry at index > current idx takes effect in the current sweep; otherwise from the next sweep. The latched request is never altered mid-REQ.
- FIFO: 4 entries, pointer wrap mod 4.
  - Push and pop in the same cycle: count unchanged, allowed even when full.
  - Pop when empty: ignored.
  - Only one read is outstanding at a time, so a free slot checked at issue is guaranteed at ack.

Test Plan:
- Entries 0 (chip 8'h10, addr 16'h0001) and 5 (chip 8'h12, addr 16'h060C) enabled; start_i; ack 3 cycles after each rd with data 16'hBEEF/16'h1234 -> exactly two rd pulses in order; out_data_o 40'h10_0001_BEEF then 40'h12_060C_1234; busy_o returns 0.
- period_i=100, enable_i=1, one entry, ack delay 2 -> rd_o rises every 100 cycles; missed_o stays 0.
- period_i=4, all 8 entries enabled, ack delay 10 -> missed_o increments per lost tick, saturates at 255, never wraps.
- out_ready_i=0, all 8 enabled -> exactly 4 reads issued, then stall in SCAN with rdo_rd_o=0. Raise out_ready_i -> remaining 4 reads complete; 8 words out, in order, none lost.
- Hold ack low, assert rst_i during REQ -> next cycle rdo_rd_o=0, out_valid_o=0, table disabled. Late ack after reset -> no FIFO write.
- No entries enabled, start_i -> busy_o high for exactly 8 cycles, rdo_rd_o never asserted.
